// File: rtl/btb_pkg.sv
// Shared BTB definitions: the feedback entry format and the PC field layout used for BTB indexing.
// PCs use big-endian bit numbering: bit 0 is the most significant bit.
package btb_pkg;

    localparam int PC_W = 32;

    // The low two bits of a PC are always zero, so they are never used for index or tag.
    localparam int BTB_IDX_LO = 22;
    localparam int BTB_IDX_HI = 29;
    localparam int BTB_TAG_LO = 0;
    localparam int BTB_TAG_HI = 21;
    localparam int BTB_IDX_W  = BTB_IDX_HI - BTB_IDX_LO + 1;
    localparam int BTB_TAG_W  = BTB_TAG_HI - BTB_TAG_LO + 1;

    typedef struct packed {
        logic [0:PC_W-1] pc;
        logic [0:PC_W-1] target;
        logic            taken;
    } fb_entry_t;

    function automatic logic [BTB_IDX_W-1:0] btb_index(input logic [0:PC_W-1] pc);
        return pc[BTB_IDX_LO:BTB_IDX_HI];
    endfunction

    function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [0:PC_W-1] pc);
        return pc[BTB_TAG_LO:BTB_TAG_HI];
    endfunction

endpackage

// File: rtl/fb_queue.sv
// Two-write / one-read circular FIFO holding pending BTB updates in program order.
// A lone write on port 1 lands in the first free slot, so the queue never develops holes.
module fb_queue
    import btb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  fb_entry_t                wr0_data,
    input  logic                     wr1_en,
    input  fb_entry_t                wr1_data,
    input  logic                     rd_en,
    output fb_entry_t                head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    fb_entry_t       mem [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW-1:0] tail_plus1;
    logic [1:0]      n_push;
    logic            rd_ok;
    fb_entry_t       slot0_data;

    always_comb begin
        slot0_data = wr0_en ? wr0_data : wr1_data;
        tail_plus1 = tail + PTRW'(1);
        n_push     = {1'b0, wr0_en} + {1'b0, wr1_en};
        rd_ok      = rd_en && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (wr0_en || wr1_en) begin
            mem[tail] <= slot0_data;
        end
        if (wr0_en && wr1_en) begin
            mem[tail_plus1] <= wr1_data;
        end
    end

    // Pointers roll over naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTRW'(rd_ok);
            tail  <= tail + PTRW'(n_push);
            count <= count + CW'(n_push) - CW'(rd_ok);
        end
    end

    assign head_data = mem[head];

endmodule

// File: rtl/btb_fb_scheduler.sv
// Collects resolved-branch reports from two requesters and drains them one per cycle
// onto the BTB update port, counting mispredictions along the way.
module btb_fb_scheduler
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [0:31]            req0_PC,
    input  logic [0:31]            req0_target,
    input  logic                   req0_taken,
    input  logic                   req0_pred_taken,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [0:31]            req1_PC,
    input  logic [0:31]            req1_target,
    input  logic                   req1_taken,
    input  logic                   req1_pred_taken,
    input  logic                   fb_hold,
    output logic                   fb_en,
    output logic [0:31]            fb_PC,
    output logic [0:31]            fb_predictedPC,
    output logic                   fb_taken,
    output logic [$clog2(DEPTH):0] count,
    output logic [CNTW-1:0]        mispredict_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] free;
    logic          push0;
    logic          push1;
    logic [1:0]    n_mispredict;
    fb_entry_t     entry0;
    fb_entry_t     entry1;
    fb_entry_t     head;

    function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a, input logic [1:0] inc);
        logic [CNTW:0] sum;
        sum = {1'b0, a} + (CNTW+1)'(inc);
        return sum[CNTW] ? {CNTW{1'b1}} : sum[CNTW-1:0];
    endfunction

    // Free space comes only from registered occupancy; a pop in the same cycle is not credited.
    always_comb begin
        free       = CW'(DEPTH) - count;
        req0_ready = (free != '0);
        req1_ready = (free >= CW'(2)) || ((free == CW'(1)) && !req0_valid);
        push0      = req0_valid && req0_ready;
        push1      = req1_valid && req1_ready;
        n_mispredict = {1'b0, push0 && (req0_taken != req0_pred_taken)}
                     + {1'b0, push1 && (req1_taken != req1_pred_taken)};
    end

    always_comb begin
        entry0 = '{pc: req0_PC, target: req0_target, taken: req0_taken};
        entry1 = '{pc: req1_PC, target: req1_target, taken: req1_taken};
    end

    fb_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .wr0_en    (push0),
        .wr0_data  (entry0),
        .wr1_en    (push1),
        .wr1_data  (entry1),
        .rd_en     (fb_en),
        .head_data (head),
        .count     (count)
    );

    assign fb_en          = (count != '0) && !fb_hold;
    assign fb_PC          = head.pc;
    assign fb_predictedPC = head.target;
    assign fb_taken       = head.taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt <= '0;
        end else begin
            mispredict_cnt <= sat_add(mispredict_cnt, n_mispredict);
        end
    end

endmodule

// File: tb/tb_btb_fb_scheduler.sv
// Directed bench for btb_fb_scheduler with a 4-entry queue and a 4-bit mispredict counter.
module tb_btb_fb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_taken, req0_pred_taken;
    logic        req1_valid, req1_ready, req1_taken, req1_pred_taken;
    logic [0:31] req0_PC, req0_target, req1_PC, req1_target;
    logic        fb_hold, fb_en, fb_taken;
    logic [0:31] fb_PC, fb_predictedPC;
    logic [2:0]  count;
    logic [3:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;

    btb_fb_scheduler #(.DEPTH(4), .CNTW(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_PC(req0_PC),
        .req0_target(req0_target), .req0_taken(req0_taken), .req0_pred_taken(req0_pred_taken),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_PC(req1_PC),
        .req1_target(req1_target), .req1_taken(req1_taken), .req1_pred_taken(req1_pred_taken),
        .fb_hold(fb_hold), .fb_en(fb_en), .fb_PC(fb_PC), .fb_predictedPC(fb_predictedPC),
        .fb_taken(fb_taken), .count(count), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_PC = '0; req0_target = '0; req0_taken = 0; req0_pred_taken = 0;
        req1_valid = 0; req1_PC = '0; req1_target = '0; req1_taken = 0; req1_pred_taken = 0;
    endtask

    task automatic drive0(input logic [0:31] pc, input logic [0:31] tgt, input logic tk, input logic pr);
        req0_valid = 1; req0_PC = pc; req0_target = tgt; req0_taken = tk; req0_pred_taken = pr;
    endtask

    task automatic drive1(input logic [0:31] pc, input logic [0:31] tgt, input logic tk, input logic pr);
        req1_valid = 1; req1_PC = pc; req1_target = tgt; req1_taken = tk; req1_pred_taken = pr;
    endtask

    task automatic test_reset();
        idle_inputs();
        fb_hold = 0;
        reset = 1;
        step(); step();
        reset = 0;
        step();
        checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL reset_fb_en: got %b expected 0", fb_en); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (mispredict_cnt !== 4'd0) begin errors++; $display("FAIL reset_mcnt: got %0d expected 0", mispredict_cnt); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_req0_ready: got %b expected 1", req0_ready); end
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL reset_req1_ready: got %b expected 1", req1_ready); end
    endtask

    task automatic test_single();
        drive0(32'h0000_1000, 32'h0000_2000, 1'b1, 1'b1);
        #1;
        checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL single_no_comb_path: got %b expected 0", fb_en); end
        step();
        idle_inputs();
        checks++; if (fb_en !== 1'b1) begin errors++; $display("FAIL single_fb_en: got %b expected 1", fb_en); end
        checks++; if (fb_PC !== 32'h0000_1000) begin errors++; $display("FAIL single_fb_PC: got %h expected 00001000", fb_PC); end
        checks++; if (fb_predictedPC !== 32'h0000_2000) begin errors++; $display("FAIL single_fb_target: got %h expected 00002000", fb_predictedPC); end
        checks++; if (fb_taken !== 1'b1) begin errors++; $display("FAIL single_fb_taken: got %b expected 1", fb_taken); end
        step();
        checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", fb_en); end
        checks++; if (mispredict_cnt !== 4'd0) begin errors++; $display("FAIL single_mcnt: got %0d expected 0", mispredict_cnt); end
    endtask

    task automatic test_dual();
        drive0(32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0);
        drive1(32'h0000_0200, 32'h0000_0300, 1'b1, 1'b1);
        step();
        idle_inputs();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL dual_count: got %0d expected 2", count); end
        checks++; if (fb_en !== 1'b1 || fb_PC !== 32'h0000_0100 || fb_taken !== 1'b0)
            begin errors++; $display("FAIL dual_first: got en=%b pc=%h tk=%b expected en=1 pc=00000100 tk=0", fb_en, fb_PC, fb_taken); end
        step();
        checks++; if (fb_en !== 1'b1 || fb_PC !== 32'h0000_0200 || fb_predictedPC !== 32'h0000_0300)
            begin errors++; $display("FAIL dual_second: got en=%b pc=%h tgt=%h expected en=1 pc=00000200 tgt=00000300", fb_en, fb_PC, fb_predictedPC); end
        step();
        checks++; if (fb_en !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL dual_empty: got en=%b count=%0d expected en=0 count=0", fb_en, count); end
    endtask

    task automatic test_hold();
        logic [0:31] pc;
        fb_hold = 1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h0000_0400 + 32'(i * 4);
            drive0(pc, pc + 32'h400, 1'(i), 1'(i));
            #1;
            checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_accept%0d: got ready=%b expected 1", i, req0_ready); end
            step();
        end
        idle_inputs();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL hold_count: got %0d expected 4", count); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            begin errors++; $display("FAIL hold_full_ready: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready); end
        checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL hold_fb_en: got %b expected 0", fb_en); end
        fb_hold = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'h0000_0400 + 32'(i * 4);
            checks++; if (fb_en !== 1'b1 || fb_PC !== pc || fb_predictedPC !== pc + 32'h400 || fb_taken !== 1'(i))
                begin errors++; $display("FAIL hold_drain%0d: got en=%b pc=%h tgt=%h tk=%b expected en=1 pc=%h", i, fb_en, fb_PC, fb_predictedPC, fb_taken, pc); end
            step();
        end
        checks++; if (fb_en !== 1'b0) begin errors++; $display("FAIL hold_after_drain: got %b expected 0", fb_en); end
    endtask

    task automatic test_free_one();
        logic [0:31] exp_pc [4];
        fb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive0(32'h0000_0A00 + 32'(i * 4), 32'h0000_1A00, 1'b0, 1'b0);
            step();
        end
        idle_inputs();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL free1_count3: got %0d expected 3", count); end
        drive0(32'h0000_0A0C, 32'h0000_1A00, 1'b0, 1'b0);
        drive1(32'h0000_0B00, 32'h0000_1B00, 1'b1, 1'b1);
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin errors++; $display("FAIL free1_both_valid: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready); end
        step();
        idle_inputs();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL free1_only_req0: got %0d expected 4", count); end
        fb_hold = 0;
        #1;
        checks++; if (fb_PC !== 32'h0000_0A00) begin errors++; $display("FAIL free1_pop: got %h expected 00000a00", fb_PC); end
        step();
        fb_hold = 1;
        drive1(32'h0000_0B00, 32'h0000_1B00, 1'b1, 1'b1);
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL free1_req1_alone: got %b expected 1", req1_ready); end
        step();
        idle_inputs();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL free1_req1_count: got %0d expected 4", count); end
        exp_pc[0] = 32'h0000_0A04; exp_pc[1] = 32'h0000_0A08;
        exp_pc[2] = 32'h0000_0A0C; exp_pc[3] = 32'h0000_0B00;
        fb_hold = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (fb_en !== 1'b1 || fb_PC !== exp_pc[i])
                begin errors++; $display("FAIL free1_drain%0d: got en=%b pc=%h expected en=1 pc=%h", i, fb_en, fb_PC, exp_pc[i]); end
            step();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL free1_empty: got %0d expected 0", count); end
    endtask

    task automatic test_mispredict();
        logic [3:0] exp_cnt;
        exp_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            drive0(32'h0000_3000 + 32'(i * 8), 32'h0000_4000, 1'b1, 1'b0);
            drive1(32'h0000_3004 + 32'(i * 8), 32'h0000_5000, 1'b0, 1'b1);
            step();
            idle_inputs();
            exp_cnt = (exp_cnt > 4'd13) ? 4'd15 : exp_cnt + 4'd2;
            checks++; if (mispredict_cnt !== exp_cnt)
                begin errors++; $display("FAIL mispredict_step%0d: got %0d expected %0d", i, mispredict_cnt, exp_cnt); end
            step(); step();
        end
    endtask

    task automatic test_reset_mid();
        fb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            drive0(32'h0000_6000 + 32'(i * 4), 32'h0000_7000, 1'b1, 1'b0);
            step();
        end
        idle_inputs();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_count3: got %0d expected 3", count); end
        fb_hold = 0;
        reset = 1;
        step();
        checks++; if (fb_en !== 1'b0 || count !== 3'd0 || mispredict_cnt !== 4'd0)
            begin errors++; $display("FAIL rstmid_cleared: got en=%b count=%0d mcnt=%0d expected 0 0 0", fb_en, count, mispredict_cnt); end
        reset = 0;
        step();
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1 || fb_en !== 1'b0)
            begin errors++; $display("FAIL rstmid_after: got r0=%b r1=%b en=%b expected 1 1 0", req0_ready, req1_ready, fb_en); end
    endtask

    initial begin
        idle_inputs();
        fb_hold = 0;
        reset = 1;
        test_reset();
        test_single();
        test_dual();
        test_hold();
        test_free_one();
        test_mispredict();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
